// File: rtl/func_call_arbiter.sv
// -----------------------------------------------------------------------------
// func_call_arbiter
//
// Shares one adder function unit between N_REQ requesters. A request is
// accepted in IDLE with a one-cycle req_ready pulse. Its operands are added
// in EXEC, and the WIDTH+1 bit sum is presented in RESP until the consumer
// takes it. Only one call is in flight at a time, so the minimum is three
// cycles per call.
//
// Configuration macro:
//   FUNC_CALL_ARB_RR_EN  defined   -> round-robin arbitration. The search
//                                     starts at a pointer that moves to
//                                     winner+1 on every grant.
//                        undefined -> fixed priority, lowest index wins,
//                                     and there is no pointer.
//
// Reset is synchronous and active-low.
// -----------------------------------------------------------------------------
module func_call_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH:0]           rsp_data,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic                     busy
);

    localparam int ID_W = $clog2(N_REQ);
    // One extra bit so that pointer + offset cannot overflow before the wrap.
    localparam int CW   = ID_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic              grant_any;
    logic [ID_W-1:0]   grant_idx;
    logic              accept;

    logic [WIDTH-1:0]  a_sel;
    logic [WIDTH-1:0]  b_sel;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [ID_W-1:0]   id_q;
    logic [WIDTH:0]    data_q;

`ifdef FUNC_CALL_ARB_RR_EN
    logic [ID_W-1:0]   rr_ptr;
    logic [CW-1:0]     cand;

    // Round-robin winner: walk the candidates rr_ptr, rr_ptr+1, ... modulo N_REQ.
    // The first candidate with an active request wins.
    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred. Combinational
        // blocks use blocking (=) assignments.
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr} + CW'(k);
            if (cand >= CW'(N_REQ)) begin
                cand = cand - CW'(N_REQ);
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (!grant_any && req_valid[i] && (cand == CW'(i))) begin
                    grant_any = 1'b1;
                    grant_idx = ID_W'(i);
                end
            end
        end
    end

    // Pointer update: after each grant, the requester after the winner gets first look.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) assignments, so every
        // register samples its inputs from before the clock edge.
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        end
    end
`else
    // Fixed-priority winner: the lowest-indexed active request wins.
    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred. Combinational
        // blocks use blocking (=) assignments.
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!grant_any && req_valid[i]) begin
                grant_any = 1'b1;
                grant_idx = ID_W'(i);
            end
        end
    end
`endif

    // Operand mux: pick the winner's arguments out of the packed buses.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                a_sel = req_a[i*WIDTH +: WIDTH];
                b_sel = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
`ifndef FUNC_CALL_ARB_RR_EN
        // NOTE: sequential state uses non-blocking (<=) assignments, so every
        // register samples its inputs from before the clock edge.
`endif
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and control outputs. A grant is held off while reset is
    // asserted, so the requester never sees an acceptance that gets discarded.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (grant_any && rst_n) begin
                    accept    = 1'b1;
                    req_ready = N_REQ'(1) << grant_idx;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: latch the winner's call on acceptance, then register the sum in
    // EXEC. Because the operands are captured, later changes on req_a/req_b
    // cannot disturb the call in flight.
    always_ff @(posedge clk) begin
        // NOTE: these are ordinary registers, not a memory array, so resetting
        // them is cheap. Resetting them also keeps rsp_data/rsp_id at zero out
        // of reset.
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            id_q   <= '0;
            data_q <= '0;
        end else begin
            if (accept) begin
                a_q  <= a_sel;
                b_q  <= b_sel;
                id_q <= grant_idx;
            end
            if (state_q == EXEC) begin
                data_q <= {1'b0, a_q} + {1'b0, b_q};
            end
        end
    end

    assign rsp_data = data_q;
    assign rsp_id   = id_q;

endmodule

// File: tb/tb_func_call_arbiter.sv
// -----------------------------------------------------------------------------
// tb_func_call_arbiter
//
// Self-checking bench for func_call_arbiter at N_REQ=4, WIDTH=8. It combines
// a table of directed vectors, hand-written multi-cycle sequences (reset,
// backpressure, contention) and a randomized run. Everything is checked
// against a call-level reference model. That model tracks whether a call is
// pending, how many cycles old it is, and its sum and owner.
// The expected arbitration follows FUNC_CALL_ARB_RR_EN in the same way as the
// design.
// -----------------------------------------------------------------------------
module tb_func_call_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [W:0]       rsp_data;
    logic [1:0]       rsp_id;
    logic             busy;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: a pending call, its age in cycles since
    // acceptance, its sum and owner, and the round-robin pointer.
    bit   m_pending;
    int   m_age;
    int   m_sum;
    int   m_id;
    int   m_ptr;

    logic [N-1:0] last_rdy;

    always #5 clk = ~clk;

    func_call_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    typedef struct {
        logic [N-1:0]   v;
        logic [N*W-1:0] a;
        logic [N*W-1:0] b;
        logic           rr;
        logic [N-1:0]   e_rdy;
        logic           e_vld;
        logic [W:0]     e_data;
        logic [1:0]     e_id;
        logic           e_busy;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Which requester the policy picks from the valid set, or -1 if none.
    function automatic int pick(input logic [N-1:0] v, input int ptr);
`ifdef FUNC_CALL_ARB_RR_EN
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
`else
        for (int j = 0; j < N; j++) begin
            if (v[j]) return j;
        end
`endif
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int j = 0; j < N; j++) begin
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_pending = 1'b0;
        m_age     = 0;
        m_sum     = 0;
        m_id      = 0;
        m_ptr     = 0;
    endtask

    // Drive one cycle's inputs, compare the outputs with the model away from
    // the clock edge, then step the model across the rising edge.
    task automatic cycle(input logic rst, input logic [N-1:0] v,
                         input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                         input logic rr);
        logic [N-1:0] e_rdy;
        logic         e_vld;
        int           w;
        rst_n     = rst;
        req_valid = v;
        req_a     = a;
        req_b     = b;
        rsp_ready = rr;
        #2;
        w     = pick(v, m_ptr);
        e_rdy = '0;
        if (rst && !m_pending && w >= 0) e_rdy[w] = 1'b1;
        e_vld = m_pending && (m_age >= 2);
        last_rdy = req_ready;
        check("req_ready", 32'(req_ready), 32'(e_rdy));
        check("rsp_valid", 32'(rsp_valid), 32'(e_vld));
        check("busy", 32'(busy), 32'(m_pending));
        if (e_vld) begin
            check("rsp_data", 32'(rsp_data), 32'(m_sum));
            check("rsp_id", 32'(rsp_id), 32'(m_id));
        end
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else if (!m_pending) begin
            if (w >= 0) begin
                m_pending = 1'b1;
                m_age     = 1;
                m_sum     = int'(a[w*W +: W]) + int'(b[w*W +: W]);
                m_id      = w;
                m_ptr     = (w + 1) % N;
            end
        end else if (m_age >= 2 && rr) begin
            m_pending = 1'b0;
        end else if (m_age < 2) begin
            m_age++;
        end
        @(negedge clk);
    endtask

    initial begin
        int grants[$];
        int exp_order[5];
        int g;

        // Table: single call, carry, operand change after acceptance, and
        // all-ones operands. Each row gives one cycle's inputs and outputs.
        tbl[0]  = '{4'b0100, 32'h0003_0000, 32'h0005_0000, 1'b1, 4'b0100, 1'b0, 9'h000, 2'd0, 1'b0};
        tbl[1]  = '{4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 9'h000, 2'd0, 1'b1};
        tbl[2]  = '{4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b1, 9'h008, 2'd2, 1'b1};
        tbl[3]  = '{4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 9'h000, 2'd0, 1'b0};
        tbl[4]  = '{4'b0001, 32'h0000_00FF, 32'h0000_0001, 1'b1, 4'b0001, 1'b0, 9'h000, 2'd0, 1'b0};
        tbl[5]  = '{4'b0001, 32'h0000_0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 9'h000, 2'd0, 1'b1};
        tbl[6]  = '{4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b1, 9'h100, 2'd0, 1'b1};
        tbl[7]  = '{4'b1000, 32'hFF00_0000, 32'hFF00_0000, 1'b1, 4'b1000, 1'b0, 9'h000, 2'd0, 1'b0};
        tbl[8]  = '{4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 9'h000, 2'd0, 1'b1};
        tbl[9]  = '{4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b1, 9'h1FE, 2'd3, 1'b1};
        tbl[10] = '{4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 9'h000, 2'd0, 1'b0};

        // Power-on reset. The outputs must come up in their reset state.
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        req_valid = 4'b1111;
        #2;
        check("reset req_ready", 32'(req_ready), 32'h0);
        check("reset rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset rsp_data", 32'(rsp_data), 32'h0);
        check("reset rsp_id", 32'(rsp_id), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        @(negedge clk);

        // Directed table.
        for (int i = 0; i < 11; i++) begin
            cycle(1'b1, tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].rr);
            check($sformatf("tbl%0d req_ready", i), 32'(last_rdy), 32'(tbl[i].e_rdy));
        end

        // Backpressure: requester 1 is held in RESP for 5 cycles while every
        // requester is asking. The response must stay put and nothing may be granted.
        cycle(1'b1, 4'b0010, 32'h0000_1200, 32'h0000_3400, 1'b0);
        check("bp grant", 32'(last_rdy), 32'h2);
        cycle(1'b1, 4'b0000, '0, '0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 4'b1111, $urandom, $urandom, 1'b0);
            check("bp rsp_valid", 32'(rsp_valid), 32'h1);
            check("bp rsp_data", 32'(rsp_data), 32'h046);
            check("bp rsp_id", 32'(rsp_id), 32'h1);
            check("bp req_ready", 32'(last_rdy), 32'h0);
        end
        cycle(1'b1, 4'b0000, '0, '0, 1'b1);
        cycle(1'b1, 4'b0000, '0, '0, 1'b1);

        // Reset in RESP aborts the call.
        cycle(1'b1, 4'b0100, 32'h0011_0000, 32'h0022_0000, 1'b0);
        cycle(1'b1, 4'b0000, '0, '0, 1'b0);
        cycle(1'b1, 4'b0000, '0, '0, 1'b0);
        check("pre-reset rsp_valid", 32'(rsp_valid), 32'h1);
        cycle(1'b0, 4'b0000, '0, '0, 1'b0);
        cycle(1'b1, 4'b0000, '0, '0, 1'b0);
        check("mid-resp reset rsp_valid", 32'(rsp_valid), 32'h0);
        check("mid-resp reset busy", 32'(busy), 32'h0);
        check("mid-resp reset req_ready", 32'(last_rdy), 32'h0);
        check("mid-resp reset rsp_data", 32'(rsp_data), 32'h0);

        // Contention with every requester asking, starting from a freshly reset pointer.
        cycle(1'b0, 4'b0000, '0, '0, 1'b1);
`ifdef FUNC_CALL_ARB_RR_EN
        exp_order = '{0, 1, 2, 3, 0};
`else
        exp_order = '{0, 0, 0, 0, 0};
`endif
        for (int c = 0; c < 40 && grants.size() < 5; c++) begin
            cycle(1'b1, 4'b1111, $urandom, $urandom, 1'b1);
            g = onehot_idx(last_rdy);
            if (g >= 0) grants.push_back(g);
        end
        check("contention grant count", 32'(grants.size()), 32'd5);
        for (int i = 0; i < 5 && i < grants.size(); i++) begin
            check($sformatf("contention grant %0d", i), 32'(grants[i]), 32'(exp_order[i]));
        end
        // Drain the call in flight, then drop requester 0. Requester 1 must be
        // next under either policy.
        for (int c = 0; c < 3; c++) cycle(1'b1, 4'b0000, '0, '0, 1'b1);
        g = -1;
        for (int c = 0; c < 10 && g < 0; c++) begin
            cycle(1'b1, 4'b1110, $urandom, $urandom, 1'b1);
            g = onehot_idx(last_rdy);
        end
        check("grant after req0 drops", 32'(g), 32'd1);

        // Randomized traffic: requests that come and go, random backpressure
        // and occasional resets.
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] v;
            v = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            cycle(($urandom_range(0, 49) != 0), v, $urandom, $urandom,
                  ($urandom_range(0, 2) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
